// File: rtl/dpdm_encode_pkg.sv
// -----------------------------------------------------------------------------
// usb_tx_pkg
// Shared definitions for the DP/DM line-level USB packet transmitter.
//   pid_t            : packet identifiers the protocol FSM may request
//   tx_state_t       : transmitter state encoding
//   SYNC_PAT         : line-level SYNC field, sent LSB first
//   *_PAT            : line-level PID fields, sent LSB first; each one ends on
//                      K so upstream NRZI for the payload starts from K
//   EOP_SE0_BITS     : number of SE0 bit times in an end-of-packet
//   pid_legal        : true for the five supported PIDs
//   pid_has_payload  : true for PIDs that are followed by a payload stream
//   pid_pattern      : maps a PID code to its line-level pattern
// -----------------------------------------------------------------------------
package usb_tx_pkg;

    typedef enum logic [2:0] {
        PID_OUT   = 3'd0,
        PID_IN    = 3'd1,
        PID_DATA0 = 3'd2,
        PID_ACK   = 3'd3,
        PID_NAK   = 3'd4
    } pid_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_PAYLOAD,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_t;

    localparam logic [7:0] SYNC_PAT  = 8'b0010_1010;
    localparam logic [7:0] ACK_PAT   = 8'b0001_1011;
    localparam logic [7:0] NAK_PAT   = 8'b0110_0011;
    localparam logic [7:0] DATA0_PAT = 8'b0001_0100;
    localparam logic [7:0] OUT_PAT   = 8'b0000_1010;
    localparam logic [7:0] IN_PAT    = 8'b0111_0010;

    localparam int EOP_SE0_BITS = 2;

    function automatic logic pid_legal(input logic [2:0] pid);
        return pid <= 3'd4;
    endfunction

    function automatic logic pid_has_payload(input logic [2:0] pid);
        return pid <= 3'd2;
    endfunction

    function automatic logic [7:0] pid_pattern(input logic [2:0] pid);
        logic [7:0] pat;
        case (pid)
            3'd0:    pat = OUT_PAT;
            3'd1:    pat = IN_PAT;
            3'd2:    pat = DATA0_PAT;
            3'd3:    pat = ACK_PAT;
            3'd4:    pat = NAK_PAT;
            default: pat = 8'h00;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/dpdm_encode_if.sv
// -----------------------------------------------------------------------------
// dpdm_encode_if
// Bundle between the protocol FSM (master) and the line transmitter (slave).
//   tx_start/tx_pid            : packet request and PID code (5..7 illegal)
//   pay_bit/pay_valid/pay_last : pre-encoded payload stream, pay_ready accepts
//   dp_out/dm_out/dpdm_oe      : pad drive values and drive enable
//   tx_busy/tx_done/tx_error   : packet status
// -----------------------------------------------------------------------------
interface dpdm_encode_if;
    import usb_tx_pkg::*;

    logic       tx_start;
    logic [2:0] tx_pid;
    logic       pay_bit;
    logic       pay_valid;
    logic       pay_last;
    logic       pay_ready;
    logic       dp_out;
    logic       dm_out;
    logic       dpdm_oe;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_start, tx_pid, pay_bit, pay_valid, pay_last,
        input  pay_ready, dp_out, dm_out, dpdm_oe, tx_busy, tx_done, tx_error
    );

    modport slave (
        input  tx_start, tx_pid, pay_bit, pay_valid, pay_last,
        output pay_ready, dp_out, dm_out, dpdm_oe, tx_busy, tx_done, tx_error
    );

endinterface

// File: rtl/dpdm_encode_piso.sv
// -----------------------------------------------------------------------------
// PISO_Register_Right
// 8-bit parallel-load right shifter; transmit counterpart of
// SIPO_Register_Right. Load has priority over shift.
//   clock, reset : clock and synchronous active-high reset
//   load, par_in : parallel load of the 8-bit word
//   shift        : shift right by one, zero fill at the top
//   ser_out      : bit 0 of the register
// -----------------------------------------------------------------------------
module PISO_Register_Right (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] par_in,
    output logic       ser_out
);

    logic [7:0] q;

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= par_in;
        end else if (shift) begin
            q <= {1'b0, q[7:1]};
        end
    end

    assign ser_out = q[0];

endmodule

// File: rtl/dpdm_encode.sv
// -----------------------------------------------------------------------------
// dpdm_encode
// Line-level USB packet transmitter: SYNC, PID, optional pre-encoded payload,
// then EOP (SE0 for two bit times, J for one), after which the bus is released.
//   clock, reset : sole clock, synchronous active-high reset
//   bus (slave)  : request/payload inputs, pad drive and status outputs
// Parameter CLKS_PER_BIT (1..255) sets how many clocks each line bit is held.
// -----------------------------------------------------------------------------
module dpdm_encode
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic         clock,
    input  logic         reset,
    dpdm_encode_if.slave bus
);

    localparam logic [7:0] CNT_MAX  = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] SE0_LAST = 3'(EOP_SE0_BITS - 1);

    tx_state_t  state_q, state_d;
    logic [7:0] bit_cnt_q;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [2:0] pid_q, pid_d;
    logic       last_q, last_d;
    logic       dp_q, dp_d;
    logic       dm_q, dm_d;
    logic       active_q;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic       boundary;
    logic       ready;
    logic       enter_eop;
    logic [7:0] pid_pat;
    logic       shreg_load;
    logic       shreg_shift;
    logic [7:0] shreg_data;
    logic       shreg_bit;

    // The shifter is loaded one bit ahead: the field's bit 0 goes straight to
    // the line register, so ser_out always holds the next bit to send.
    PISO_Register_Right u_shreg (
        .clock   (clock),
        .reset   (reset),
        .load    (shreg_load),
        .shift   (shreg_shift),
        .par_in  (shreg_data),
        .ser_out (shreg_bit)
    );

    assign boundary = (bit_cnt_q == CNT_MAX);
    assign pid_pat  = pid_pattern(pid_q);

    // Next-state logic. Outside IDLE everything moves only on bit boundaries.
    // A payload request (ready) and an EOP entry are resolved after the case
    // so PID and PAYLOAD share the same accept/underrun handling.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        pid_d       = pid_q;
        last_d      = last_q;
        dp_d        = dp_q;
        dm_d        = dm_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        shreg_load  = 1'b0;
        shreg_shift = 1'b0;
        shreg_data  = '0;
        ready       = 1'b0;
        enter_eop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                dp_d = 1'b1;
                dm_d = 1'b0;
                if (bus.tx_start) begin
                    if (pid_legal(bus.tx_pid)) begin
                        state_d    = ST_SYNC;
                        pid_d      = bus.tx_pid;
                        bit_idx_d  = '0;
                        shreg_load = 1'b1;
                        shreg_data = {1'b0, SYNC_PAT[7:1]};
                        dp_d       = SYNC_PAT[0];
                        dm_d       = ~SYNC_PAT[0];
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end

            ST_SYNC, ST_PID: begin
                if (boundary) begin
                    if (bit_idx_q != 3'd7) begin
                        shreg_shift = 1'b1;
                        dp_d        = shreg_bit;
                        dm_d        = ~shreg_bit;
                        bit_idx_d   = bit_idx_q + 3'd1;
                    end else if (state_q == ST_SYNC) begin
                        state_d    = ST_PID;
                        bit_idx_d  = '0;
                        shreg_load = 1'b1;
                        shreg_data = {1'b0, pid_pat[7:1]};
                        dp_d       = pid_pat[0];
                        dm_d       = ~pid_pat[0];
                    end else if (pid_has_payload(pid_q)) begin
                        ready = 1'b1;
                    end else begin
                        enter_eop = 1'b1;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (boundary) begin
                    if (last_q) begin
                        enter_eop = 1'b1;
                    end else begin
                        ready = 1'b1;
                    end
                end
            end

            ST_EOP_SE0: begin
                if (boundary) begin
                    if (bit_idx_q == SE0_LAST) begin
                        state_d = ST_EOP_J;
                        dp_d    = 1'b1;
                        dm_d    = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

            ST_EOP_J: begin
                if (boundary) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An underrun aborts with a clean EOP rather than holding the line.
        if (ready) begin
            if (bus.pay_valid) begin
                state_d = ST_PAYLOAD;
                dp_d    = bus.pay_bit;
                dm_d    = ~bus.pay_bit;
                last_d  = bus.pay_last;
            end else begin
                error_d   = 1'b1;
                enter_eop = 1'b1;
            end
        end

        if (enter_eop) begin
            state_d   = ST_EOP_SE0;
            bit_idx_d = '0;
            dp_d      = 1'b0;
            dm_d      = 1'b0;
        end
    end

    // State, line and status registers. The bit timer idles at zero so the
    // first bit after leaving IDLE gets a full CLKS_PER_BIT cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            pid_q     <= '0;
            last_q    <= 1'b0;
            dp_q      <= 1'b1;
            dm_q      <= 1'b0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            pid_q     <= pid_d;
            last_q    <= last_d;
            dp_q      <= dp_d;
            dm_q      <= dm_d;
            active_q  <= (state_d != ST_IDLE);
            done_q    <= done_d;
            error_q   <= error_d;
            if ((state_q == ST_IDLE) || boundary) begin
                bit_cnt_q <= '0;
            end else begin
                bit_cnt_q <= bit_cnt_q + 8'd1;
            end
        end
    end

    assign bus.pay_ready = ready;
    assign bus.dp_out    = dp_q;
    assign bus.dm_out    = dm_q;
    assign bus.dpdm_oe   = active_q;
    assign bus.tx_busy   = active_q;
    assign bus.tx_done   = done_q;
    assign bus.tx_error  = error_q;

endmodule

// File: tb/tb_dpdm_encode.sv
// -----------------------------------------------------------------------------
// tb_dpdm_encode
// Bench for dpdm_encode. Two instances (CLKS_PER_BIT = 1 and 4) share the
// stimulus; sel picks which one receives tx_start and which one is observed.
// Expected waveforms are built from the packet layout as a list of line
// symbols, one per bit, stretched by the bit time.
// -----------------------------------------------------------------------------
module tb_dpdm_encode;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sel;
    logic       start;
    logic [2:0] pid;
    logic       pbit;
    logic       pvalid;
    logic       plast;

    int n_checks = 0;
    int n_pass   = 0;

    dpdm_encode_if bus1 ();
    dpdm_encode_if bus4 ();

    dpdm_encode #(.CLKS_PER_BIT(1)) dut_fast (
        .clock (clk),
        .reset (rst),
        .bus   (bus1.slave)
    );

    dpdm_encode #(.CLKS_PER_BIT(4)) dut_slow (
        .clock (clk),
        .reset (rst),
        .bus   (bus4.slave)
    );

    assign bus1.tx_start  = start & ~sel;
    assign bus4.tx_start  = start & sel;
    assign bus1.tx_pid    = pid;
    assign bus4.tx_pid    = pid;
    assign bus1.pay_bit   = pbit;
    assign bus4.pay_bit   = pbit;
    assign bus1.pay_valid = pvalid;
    assign bus4.pay_valid = pvalid;
    assign bus1.pay_last  = plast;
    assign bus4.pay_last  = plast;

    logic o_dp, o_dm, o_oe, o_busy, o_done, o_err, o_ready;
    assign o_dp    = sel ? bus4.dp_out    : bus1.dp_out;
    assign o_dm    = sel ? bus4.dm_out    : bus1.dm_out;
    assign o_oe    = sel ? bus4.dpdm_oe   : bus1.dpdm_oe;
    assign o_busy  = sel ? bus4.tx_busy   : bus1.tx_busy;
    assign o_done  = sel ? bus4.tx_done   : bus1.tx_done;
    assign o_err   = sel ? bus4.tx_error  : bus1.tx_error;
    assign o_ready = sel ? bus4.pay_ready : bus1.pay_ready;

    localparam logic [7:0] TB_SYNC = 8'b0010_1010;

    // Line-level PID values, kept independent of the design package
    function automatic logic [7:0] tb_pattern(input logic [2:0] p);
        case (p)
            3'd0:    return 8'b0000_1010;
            3'd1:    return 8'b0111_0010;
            3'd2:    return 8'b0001_0100;
            3'd3:    return 8'b0001_1011;
            3'd4:    return 8'b0110_0011;
            default: return 8'h00;
        endcase
    endfunction

    // Receive-side PID classification of a captured bit stream
    function automatic int tb_classify(input logic [7:0] sync_b, input logic [7:0] pid_b);
        if (sync_b != TB_SYNC) return -1;
        for (int k = 0; k < 5; k++) begin
            if (pid_b == tb_pattern(3'(k))) return k;
        end
        return -1;
    endfunction

    // Sends one packet and checks every cycle from the accept edge through
    // one cycle after tx_done. under >= 0 withholds that payload bit.
    // busy_at > 0 pulses a second tx_start during that cycle.
    task automatic run_packet(input string name, input logic [2:0] p, input int n,
                              input logic [63:0] payload, input int under, input int busy_at);
        int         cpb;
        int         sym[$];
        logic [7:0] pat;
        logic       has_pay;
        int         nready;
        int         err_cycle;
        int         total;
        int         k_acc;
        logic [6:0] exp_v;
        logic [6:0] got_v;
        logic       rx[$];
        logic [7:0] rx_sync;
        logic [7:0] rx_pid;
        int         s;
        int         bidx;

        cpb       = sel ? 4 : 1;
        pat       = tb_pattern(p);
        has_pay   = (p <= 3'd2);
        err_cycle = -1;
        nready    = 0;
        for (int i = 0; i < 8; i++) sym.push_back(int'(TB_SYNC[i]));
        for (int i = 0; i < 8; i++) sym.push_back(int'(pat[i]));
        if (has_pay) begin
            for (int i = 0; i < n; i++) begin
                nready++;
                if (i == under) begin
                    err_cycle = (16 + i) * cpb + 1;
                    break;
                end
                sym.push_back(int'(payload[i]));
            end
        end
        sym.push_back(2);
        sym.push_back(2);
        sym.push_back(1);
        total = sym.size() * cpb;

        k_acc = 0;
        @(negedge clk);
        start  = 1'b1;
        pid    = p;
        pvalid = 1'b0;
        @(posedge clk);

        for (int c = 1; c <= total + 2; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (busy_at > 0 && c == busy_at) begin
                start = 1'b1;
                pid   = 3'd3;
            end
            if (busy_at > 0 && c == busy_at + 1) start = 1'b0;

            if (c <= total) begin
                s        = sym[(c - 1) / cpb];
                exp_v[6] = (s == 1);
                exp_v[5] = (s == 0);
                exp_v[4] = 1'b1;
                exp_v[3] = 1'b1;
                exp_v[2] = 1'b0;
            end else begin
                exp_v[6] = 1'b1;
                exp_v[5] = 1'b0;
                exp_v[4] = 1'b0;
                exp_v[3] = 1'b0;
                exp_v[2] = (c == total + 1);
            end
            exp_v[1] = (c == err_cycle);
            bidx     = c / cpb - 16;
            exp_v[0] = has_pay && (c % cpb == 0) && (bidx >= 0) && (bidx < nready);

            got_v = {o_dp, o_dm, o_oe, o_busy, o_done, o_err, o_ready};
            n_checks++;
            if (got_v !== exp_v) begin
                $display("[TB] FAIL %s cycle %0d {dp,dm,oe,busy,done,err,ready}: got %b, expected %b",
                         name, c, got_v, exp_v);
            end else begin
                n_pass++;
            end

            if (c <= total && (c - 1) % cpb == 0) rx.push_back(o_dp);

            // Present the payload bit for the boundary that closes this cycle
            pbit   = (k_acc < 64) ? payload[k_acc] : 1'b0;
            plast  = (k_acc == n - 1);
            pvalid = (k_acc != under);
            if (o_ready) k_acc++;
        end
        pvalid = 1'b0;

        for (int i = 0; i < 8; i++) begin
            rx_sync[i] = rx[i];
            rx_pid[i]  = rx[8 + i];
        end
        n_checks++;
        if (tb_classify(rx_sync, rx_pid) !== int'(p)) begin
            $display("[TB] FAIL %s loopback pid: decoded %0d, expected %0d",
                     name, tb_classify(rx_sync, rx_pid), p);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset();
        logic [6:0] got1, got4;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        got1 = {bus1.dp_out, bus1.dm_out, bus1.dpdm_oe, bus1.tx_busy, bus1.tx_done, bus1.tx_error, bus1.pay_ready};
        got4 = {bus4.dp_out, bus4.dm_out, bus4.dpdm_oe, bus4.tx_busy, bus4.tx_done, bus4.tx_error, bus4.pay_ready};
        n_checks++;
        if (got1 !== 7'b1000000) $display("[TB] FAIL reset fast: got %b, expected 1000000", got1);
        else n_pass++;
        n_checks++;
        if (got4 !== 7'b1000000) $display("[TB] FAIL reset slow: got %b, expected 1000000", got4);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_ack();
        sel = 1'b0;
        run_packet("ack", 3'd3, 0, 64'h0, -1, 0);
        run_packet("nak", 3'd4, 0, 64'h0, -1, 0);
    endtask

    task automatic test_data0_payload();
        sel = 1'b0;
        run_packet("data0_a5c3", 3'd2, 16, 64'hA5C3, -1, 0);
    endtask

    task automatic test_random_packets();
        sel = 1'b0;
        for (int t = 0; t < 8; t++) begin
            run_packet("random", 3'($urandom_range(0, 4)), int'($urandom_range(1, 24)),
                       {$urandom, $urandom}, -1, 0);
        end
    endtask

    task automatic test_slow_bits();
        sel = 1'b1;
        run_packet("slow_nak", 3'd4, 0, 64'h0, -1, 0);
        run_packet("slow_in", 3'd1, int'($urandom_range(1, 10)), {$urandom, $urandom}, -1, 0);
        run_packet("slow_underrun", 3'd2, 8, {$urandom, $urandom}, 2, 0);
        sel = 1'b0;
    endtask

    task automatic test_underrun();
        sel = 1'b0;
        run_packet("underrun_5th", 3'd2, 12, {$urandom, $urandom}, 4, 0);
        run_packet("underrun_1st", 3'd0, 6, {$urandom, $urandom}, 0, 0);
    endtask

    task automatic test_illegal_pid();
        logic [5:0] got_v;
        sel = 1'b0;
        @(negedge clk);
        start = 1'b1;
        pid   = 3'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        got_v = {o_dp, o_dm, o_oe, o_busy, o_done, o_err};
        n_checks++;
        if (got_v !== 6'b100001) $display("[TB] FAIL illegal_pid pulse: got %b, expected 100001", got_v);
        else n_pass++;
        @(negedge clk);
        got_v = {o_dp, o_dm, o_oe, o_busy, o_done, o_err};
        n_checks++;
        if (got_v !== 6'b100000) $display("[TB] FAIL illegal_pid after: got %b, expected 100000", got_v);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        run_packet("start_while_busy", 3'd2, 5, {$urandom, $urandom}, -1, 5);
        run_packet("back_to_back", 3'd3, 0, 64'h0, -1, 0);
    endtask

    task automatic test_reset_mid();
        logic [5:0] got_v;
        sel = 1'b0;
        @(negedge clk);
        start = 1'b1;
        pid   = 3'd1;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        got_v = {o_dp, o_dm, o_oe, o_busy, o_done, o_err};
        n_checks++;
        if (got_v !== 6'b100000) $display("[TB] FAIL reset_mid: got %b, expected 100000", got_v);
        else n_pass++;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            got_v = {o_dp, o_dm, o_oe, o_busy, o_done, o_err};
            n_checks++;
            if (got_v !== 6'b100000) $display("[TB] FAIL reset_mid idle %0d: got %b, expected 100000", c, got_v);
            else n_pass++;
        end
        run_packet("ack_after_reset", 3'd3, 0, 64'h0, -1, 0);
    endtask

    initial begin
        rst    = 1'b1;
        sel    = 1'b0;
        start  = 1'b0;
        pid    = 3'd0;
        pbit   = 1'b0;
        pvalid = 1'b0;
        plast  = 1'b0;
        test_reset();
        test_ack();
        test_data0_payload();
        test_random_packets();
        test_slow_bits();
        test_underrun();
        test_illegal_pid();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
